// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate-by-count unit, one bit per cycle.
// Runs the counted forms of ROL/ROR/ROLC/RORC/SHL/SHR/SHRA and returns the
// result with a flag vector and write mask in the ALU's PSW bit layout.
//
// Ports:
//   clk, reset       core clock, synchronous active-high reset
//   start            request, accepted on any edge where the unit is not in RUN
//   op[2:0]          0 ROL, 1 ROR, 2 ROLC, 3 RORC, 4 SHL, 5 SHR, 6 SHRA, 7 reserved
//   size             0 = byte (bits 15:8 pass through), 1 = word
//   operand[15:0]    value to shift
//   count[7:0]       shift count, low COUNT_BITS bits used
//   cy_in            PSW CY, carry-in for ROLC/RORC
//   busy             high while in RUN
//   done             one-cycle pulse when result/flags are valid
//   result[15:0]     shifted value
//   flags_out[5:0]   {Z, S, P, V, CY, AC}
//   flags_wr[5:0]    per-flag write enable, same order as flags_out
module shift_sequencer #(
    parameter int unsigned COUNT_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        size,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    input  logic        cy_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [5:0]  flags_out,
    output logic [5:0]  flags_wr
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 6;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ROL  = 3'd0;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd1;
    localparam logic [OP_W-1:0] OP_ROLC = 3'd2;
    localparam logic [OP_W-1:0] OP_RORC = 3'd3;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHRA = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

    localparam logic [FLAG_W-1:0] WR_ROT   = 6'b000110;
    localparam logic [FLAG_W-1:0] WR_SHIFT = 6'b111110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic                    size_q, size_d;
    logic [DATA_W-1:0]       x_q, x_d;
    logic                    c_q, c_d;
    logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
    logic                    orig_msb_q, orig_msb_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_W-1:0]       result_q, result_d;
    logic [FLAG_W-1:0]       flags_out_q, flags_out_d;
    logic [FLAG_W-1:0]       flags_wr_q, flags_wr_d;

    logic                    step_msb_c;
    logic                    step_fill_c;
    logic                    step_left_c;
    logic [DATA_W-1:0]       step_x_c;
    logic                    step_c_c;
    logic [FLAG_W-1:0]       step_flags_c;
    logic [FLAG_W-1:0]       step_wr_c;
    logic [COUNT_BITS-1:0]   eff_cnt_c;
    logic                    accept_c;
    logic                    unused_count_c;

    assign eff_cnt_c      = count[COUNT_BITS-1:0];
    assign accept_c       = start && (state_q != ST_RUN);
    assign unused_count_c = ^count;

    // One bit step of the latched operation on x_q/c_q; byte mode keeps bits 15:8.
    always_comb begin
        step_msb_c  = size_q ? x_q[15] : x_q[7];
        step_fill_c = 1'b0;
        step_left_c = 1'b0;
        case (op_q)
            OP_ROL:  begin step_left_c = 1'b1; step_fill_c = step_msb_c; end
            OP_ROLC: begin step_left_c = 1'b1; step_fill_c = c_q;        end
            OP_SHL:  begin step_left_c = 1'b1; step_fill_c = 1'b0;       end
            OP_ROR:  step_fill_c = x_q[0];
            OP_RORC: step_fill_c = c_q;
            OP_SHRA: step_fill_c = step_msb_c;
            default: step_fill_c = 1'b0;
        endcase
        if (step_left_c) begin
            step_c_c = step_msb_c;
            step_x_c = size_q ? {x_q[14:0], step_fill_c}
                              : {x_q[15:8], x_q[6:0], step_fill_c};
        end else begin
            step_c_c = x_q[0];
            step_x_c = size_q ? {step_fill_c, x_q[15:1]}
                              : {x_q[15:8], step_fill_c, x_q[7:1]};
        end
    end

    // Final flags as they would be if this step is the last one.
    always_comb begin
        logic r_msb;
        logic r_msb1;
        logic z;
        logic p;
        logic v;
        r_msb  = size_q ? step_x_c[15] : step_x_c[7];
        r_msb1 = size_q ? step_x_c[14] : step_x_c[6];
        z      = size_q ? (step_x_c == 16'h0000) : (step_x_c[7:0] == 8'h00);
        p      = ~^step_x_c[7:0];
        v      = 1'b0;
        step_wr_c = WR_SHIFT;
        case (op_q)
            OP_ROL, OP_ROLC: begin v = r_msb ^ step_c_c; step_wr_c = WR_ROT; end
            OP_ROR, OP_RORC: begin v = r_msb ^ r_msb1;   step_wr_c = WR_ROT; end
            OP_SHL:  v = r_msb ^ step_c_c;
            OP_SHR:  v = orig_msb_q;
            default: v = 1'b0;
        endcase
        step_flags_c = {z, r_msb, p, v, step_c_c, 1'b0};
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        size_d      = size_q;
        x_d         = x_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        orig_msb_d  = orig_msb_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        flags_wr_d  = flags_wr_q;

        case (state_q)
            ST_RUN: begin
                busy_d = 1'b1;
                x_d    = step_x_c;
                c_d    = step_c_c;
                cnt_d  = cnt_q - COUNT_BITS'(1);
                if (cnt_q == COUNT_BITS'(1)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = step_x_c;
                    flags_out_d = step_flags_c;
                    flags_wr_d  = step_wr_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start in IDLE or DONE begins a new operation (back-to-back allowed).
        if (accept_c) begin
            op_d       = op;
            size_d     = size;
            x_d        = operand;
            c_d        = cy_in;
            cnt_d      = eff_cnt_c;
            orig_msb_d = size ? operand[15] : operand[7];
            if ((eff_cnt_c == '0) || (op == OP_RSVD)) begin
                state_d     = ST_DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                result_d    = operand;
                flags_out_d = '0;
                flags_wr_d  = '0;
            end else begin
                state_d = ST_RUN;
                busy_d  = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            size_q      <= 1'b0;
            x_q         <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            orig_msb_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            flags_out_q <= '0;
            flags_wr_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            size_q      <= size_d;
            x_q         <= x_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            orig_msb_q  <= orig_msb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
            flags_wr_q  <= flags_wr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;
    assign flags_wr  = flags_wr_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        size;
    logic [15:0] operand;
    logic [7:0]  count;
    logic        cy_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [5:0]  flags_out;
    logic [5:0]  flags_wr;

    int n_checks;
    int n_fail;

    shift_sequencer #(.COUNT_BITS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .size     (size),
        .operand  (operand),
        .count    (count),
        .cy_in    (cy_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flags_out(flags_out),
        .flags_wr (flags_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for done; lat is the cycle (1 = first after accept).
    task automatic run_op(input logic [2:0] o, input logic s, input logic [15:0] opnd,
                          input logic [7:0] cnt, input logic cy, output int lat);
        op = o; size = s; operand = opnd; count = cnt; cy_in = cy; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: done never rose, waited %0d cycles", lat);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; size = 1'b0; operand = '0; count = '0; cy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, result, flags_out, flags_wr} !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h flags=%h wr=%h, want all 0",
                     busy, done, result, flags_out, flags_wr);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_rol();
        int lat;
        run_op(3'd0, 1'b0, 16'h1281, 8'd1, 1'b0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rol_latency: got %0d want 2", lat); end
        n_checks++;
        if (result !== 16'h1203) begin n_fail++; $display("FAIL rol_result: got %h want 1203", result); end
        n_checks++;
        if (flags_out !== 6'h0E) begin n_fail++; $display("FAIL rol_flags: got %h want 0e", flags_out); end
        n_checks++;
        if (flags_wr !== 6'h06) begin n_fail++; $display("FAIL rol_wr: got %h want 06", flags_wr); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rol_done_pulse: done still %b, want 0", done); end
    endtask

    task automatic test_word_shl();
        int lat;
        run_op(3'd4, 1'b1, 16'h8001, 8'd4, 1'b0, lat);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL shl_latency: got %0d want 5", lat); end
        n_checks++;
        if (result !== 16'h0010) begin n_fail++; $display("FAIL shl_result: got %h want 0010", result); end
        n_checks++;
        if (flags_out !== 6'h00) begin n_fail++; $display("FAIL shl_flags: got %h want 00", flags_out); end
        n_checks++;
        if (flags_wr !== 6'h3E) begin n_fail++; $display("FAIL shl_wr: got %h want 3e", flags_wr); end
    endtask

    task automatic test_byte_rorc();
        int lat;
        run_op(3'd3, 1'b0, 16'h0001, 8'd9, 1'b1, lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL rorc_latency: got %0d want 10", lat); end
        n_checks++;
        if (result !== 16'h0001) begin n_fail++; $display("FAIL rorc_result: got %h want 0001", result); end
        n_checks++;
        if (flags_out !== 6'h02) begin n_fail++; $display("FAIL rorc_flags: got %h want 02", flags_out); end
        n_checks++;
        if (flags_wr !== 6'h06) begin n_fail++; $display("FAIL rorc_wr: got %h want 06", flags_wr); end
    endtask

    task automatic test_word_shr_mask();
        int lat;
        run_op(3'd5, 1'b1, 16'hFFFF, 8'h21, 1'b0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL shr1_latency: got %0d want 2", lat); end
        n_checks++;
        if (result !== 16'h7FFF) begin n_fail++; $display("FAIL shr1_result: got %h want 7fff", result); end
        n_checks++;
        if (flags_out !== 6'h0E) begin n_fail++; $display("FAIL shr1_flags: got %h want 0e", flags_out); end
        n_checks++;
        if (flags_wr !== 6'h3E) begin n_fail++; $display("FAIL shr1_wr: got %h want 3e", flags_wr); end
        @(posedge clk); #1;
        run_op(3'd5, 1'b1, 16'hFFFF, 8'h20, 1'b0, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL shr0_latency: got %0d want 1", lat); end
        n_checks++;
        if (result !== 16'hFFFF) begin n_fail++; $display("FAIL shr0_result: got %h want ffff", result); end
        n_checks++;
        if (flags_wr !== 6'h00) begin n_fail++; $display("FAIL shr0_wr: got %h want 00", flags_wr); end
    endtask

    task automatic test_reserved_op();
        int lat;
        @(posedge clk); #1;
        run_op(3'd7, 1'b1, 16'hABCD, 8'd5, 1'b0, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL rsvd_latency: got %0d want 1", lat); end
        n_checks++;
        if ({result, flags_wr} !== {16'hABCD, 6'h00}) begin
            n_fail++; $display("FAIL rsvd_result: got %h/%h want abcd/00", result, flags_wr);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        run_op(3'd6, 1'b0, 16'h3480, 8'd3, 1'b0, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL shra_latency: got %0d want 4", lat); end
        n_checks++;
        if (result !== 16'h34F0) begin n_fail++; $display("FAIL shra_result: got %h want 34f0", result); end
        n_checks++;
        if (flags_out !== 6'h18) begin n_fail++; $display("FAIL shra_flags: got %h want 18", flags_out); end
        // New start during the DONE cycle: word ROR 0x0001 by 1.
        op = 3'd1; size = 1'b1; operand = 16'h0001; count = 8'd1; cy_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand = 16'h5555; op = 3'd4; count = 8'd7;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
        n_checks++;
        if ({result, flags_out, flags_wr} !== {16'h8000, 6'h1E, 6'h06}) begin
            n_fail++; $display("FAIL b2b_result: got %h/%h/%h want 8000/1e/06", result, flags_out, flags_wr);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen_done;
        @(posedge clk); #1;
        op = 3'd0; size = 1'b1; operand = 16'h1234; count = 8'd31; cy_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, result, flags_out, flags_wr} !== 30'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h flags=%h wr=%h, want all 0",
                     busy, done, result, flags_out, flags_wr);
        end
        seen_done = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen_done); end
        run_op(3'd0, 1'b1, 16'h8001, 8'd1, 1'b0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 2", lat); end
        n_checks++;
        if ({result, flags_out, flags_wr} !== {16'h0003, 6'h0E, 6'h06}) begin
            n_fail++; $display("FAIL post_reset_result: got %h/%h/%h want 0003/0e/06", result, flags_out, flags_wr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_byte_rol();
        test_word_shl();
        test_byte_rorc();
        test_word_shr_mask();
        test_reserved_op();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
